// File: rtl/can_pkg.sv
// Shared CAN definitions: field lengths, CRC-15 constants, transmit FSM
// state encoding and the serial CRC-15 update step.
package can_pkg;

    // CRC-15 generator: x^15+x^14+x^10+x^8+x^7+x^4+x^3+1
    localparam logic [14:0] CAN_CRC_POLY    = 15'h4599;

    // Bits from SOF through the DLC field
    localparam logic [6:0]  CAN_STD_HDR_LEN = 7'd19;
    localparam logic [6:0]  CAN_EXT_HDR_LEN = 7'd39;

    localparam int          CAN_CRC_LEN     = 15;
    // Longest SOF-through-data image (extended header + 8 data bytes)
    localparam int          CAN_IMAGE_LEN   = 103;

    // Transmit FSM encoding
    typedef logic [1:0] can_state_t;
    localparam can_state_t  ST_IDLE  = 2'd0;
    localparam can_state_t  ST_FRAME = 2'd1;
    localparam can_state_t  ST_CRC   = 2'd2;

    // One serial CRC-15 step. Feeding back the register's own MSB makes the
    // feedback term zero, so the same step doubles as a plain left shift
    // while the CRC itself is being transmitted.
    function automatic logic [14:0] crc15_step(input logic [14:0] crc,
                                               input logic        bitin,
                                               input logic [14:0] poly);
        logic fb;
        fb = bitin ^ crc[14];
        return {crc[13:0], 1'b0} ^ (fb ? poly : 15'h0000);
    endfunction

endpackage

// File: rtl/tshiftreg2_if.sv
// Frame-load / shift-request bundle between the MAC and the transmit
// shift register.
interface tshiftreg2_if;
    import can_pkg::*;

    // Protocol: load is a one-cycle pulse accepted only while busy=0; the
    // frame fields are sampled on that edge only. activ is a level request
    // and each 0->1 transition moves exactly one bit; bitout changes on the
    // edge that saw the rising activ. abort drops any frame in progress.
    // done pulses for one cycle after the final CRC bit has been shifted.
    logic        load;
    logic        activ;
    logic        abort;
    logic        ide;
    logic        rtr;
    logic [67:0] mesin_a;   // [67:64] DLC, [63:0] data, byte 0 at [63:56]
    logic [17:0] mesin_b;   // extended ID
    logic [10:0] mesin_c;   // base ID
    logic        bitout;
    logic        busy;
    logic        crc_phase;
    logic        done;
    can_state_t  dbg_state; // FSM state, for observation only

    modport master (
        output load, activ, abort, ide, rtr, mesin_a, mesin_b, mesin_c,
        input  bitout, busy, crc_phase, done, dbg_state
    );

    modport slave (
        input  load, activ, abort, ide, rtr, mesin_a, mesin_b, mesin_c,
        output bitout, busy, crc_phase, done, dbg_state
    );

endinterface

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 register. clear takes priority over enable; one bit is
// absorbed per enabled cycle.
module can_crc15
    import can_pkg::*;
#(
    parameter logic [14:0] POLY = CAN_CRC_POLY,
    parameter logic [14:0] INIT = 15'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        bitin,
    output logic [14:0] crc
);

    logic [14:0] crc_q;
    logic [14:0] crc_d;

    // Next CRC value: restart, absorb one bit, or hold
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = INIT;
        end else if (enable) begin
            crc_d = crc15_step(crc_q, bitin, POLY);
        end
    end

    // CRC register
    always_ff @(posedge clock) begin
        if (reset) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/tshiftreg2.sv
// CAN transmit shift register: parallel-loads a frame image, shifts it out
// MSB-first on each activ rising edge, then appends the CRC-15.
module tshiftreg2
    import can_pkg::*;
#(
    parameter logic [14:0] CRC_POLY = CAN_CRC_POLY,
    parameter logic [14:0] CRC_INIT = 15'h0000
) (
    input  logic        clock,
    input  logic        reset,
    tshiftreg2_if.slave bus
);

    // SOF is always dominant and lives in bitout at load, so the image
    // register only holds the bits that follow it.
    localparam int IMG_W = CAN_IMAGE_LEN - 1;

    can_state_t       state_q, state_d;
    logic [IMG_W-1:0] image_q, image_d;
    logic [6:0]       len_q, len_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [3:0]       crc_cnt_q, crc_cnt_d;
    logic             activ_q, activ_d;
    logic             bitout_q, bitout_d;
    logic             busy_q, busy_d;
    logic             crc_phase_q, crc_phase_d;
    logic             done_q, done_d;

    logic             strobe;
    logic             crc_clear;
    logic             crc_en;
    logic [14:0]      crc;
    logic             crc_fb;
    logic             crc_nxt_msb;
    logic [IMG_W-1:0] img_new;
    logic [6:0]       len_new;
    logic [6:0]       data_bits;
    logic [3:0]       dlc;

    assign strobe = bus.activ & ~activ_q;
    assign dlc    = bus.mesin_a[67:64];

    // MSB of the CRC after absorbing the current bitout; in the CRC state
    // the feedback cancels and this is simply the next CRC bit.
    assign crc_fb      = bitout_q ^ crc[14];
    assign crc_nxt_msb = crc[13] ^ (crc_fb & CRC_POLY[14]);

    can_crc15 #(
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (crc_en),
        .bitin  (bitout_q),
        .crc    (crc)
    );

    // Frame image (post-SOF, left-justified) and its transmitted length
    always_comb begin
        img_new   = '0;
        data_bits = 7'd0;
        if (!bus.rtr) begin
            // DLC 9..15 still carries eight bytes of data
            data_bits = dlc[3] ? 7'd64 : {1'b0, dlc[2:0], 3'b000};
        end
        if (bus.ide) begin
            img_new = {bus.mesin_c, 2'b11, bus.mesin_b, bus.rtr, 2'b00,
                       dlc, bus.mesin_a[63:0]};
            len_new = CAN_EXT_HDR_LEN + data_bits;
        end else begin
            img_new = {bus.mesin_c, bus.rtr, 2'b00, dlc,
                       bus.mesin_a[63:0], 20'h00000};
            len_new = CAN_STD_HDR_LEN + data_bits;
        end
    end

    // Transmit FSM: abort beats strobe, strobe beats load
    always_comb begin
        state_d     = state_q;
        image_d     = image_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        crc_cnt_d   = crc_cnt_q;
        activ_d     = bus.activ;
        bitout_d    = bitout_q;
        busy_d      = busy_q;
        crc_phase_d = crc_phase_q;
        done_d      = 1'b0;
        crc_clear   = 1'b0;
        crc_en      = 1'b0;

        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            bitout_d    = 1'b1;
            busy_d      = 1'b0;
            crc_phase_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.load && !bus.abort) begin
                        image_d     = img_new;
                        len_d       = len_new;
                        cnt_d       = 7'd0;
                        crc_cnt_d   = 4'd0;
                        crc_clear   = 1'b1;
                        state_d     = ST_FRAME;
                        busy_d      = 1'b1;
                        bitout_d    = 1'b0;
                    end
                end
                ST_FRAME: begin
                    if (strobe) begin
                        crc_en  = 1'b1;
                        image_d = {image_q[IMG_W-2:0], 1'b0};
                        cnt_d   = cnt_q + 7'd1;
                        if (cnt_q == len_q - 7'd1) begin
                            state_d     = ST_CRC;
                            crc_phase_d = 1'b1;
                            crc_cnt_d   = 4'd0;
                            bitout_d    = crc_nxt_msb;
                        end else begin
                            bitout_d    = image_q[IMG_W-1];
                        end
                    end
                end
                ST_CRC: begin
                    if (strobe) begin
                        crc_en    = 1'b1;
                        crc_cnt_d = crc_cnt_q + 4'd1;
                        if (crc_cnt_q == 4'(CAN_CRC_LEN - 1)) begin
                            state_d     = ST_IDLE;
                            busy_d      = 1'b0;
                            crc_phase_d = 1'b0;
                            bitout_d    = 1'b1;
                            done_d      = 1'b1;
                        end else begin
                            bitout_d    = crc_nxt_msb;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    bitout_d    = 1'b1;
                    busy_d      = 1'b0;
                    crc_phase_d = 1'b0;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            image_q     <= '0;
            len_q       <= 7'd0;
            cnt_q       <= 7'd0;
            crc_cnt_q   <= 4'd0;
            activ_q     <= 1'b0;
            bitout_q    <= 1'b1;
            busy_q      <= 1'b0;
            crc_phase_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            image_q     <= image_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            crc_cnt_q   <= crc_cnt_d;
            activ_q     <= activ_d;
            bitout_q    <= bitout_d;
            busy_q      <= busy_d;
            crc_phase_q <= crc_phase_d;
            done_q      <= done_d;
        end
    end

    assign bus.bitout    = bitout_q;
    assign bus.busy      = busy_q;
    assign bus.crc_phase = crc_phase_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

endmodule
